// File: rtl/qspi_rd_pkg.sv
// Shared constants for the QSPI read engine: FSM state codes, opcodes, cmd_id encoding.
// Latency: n/a (constants and a pure decode function).
// Backpressure: n/a.
package qspi_rd_pkg;

  typedef logic [2:0] state_t;

  localparam state_t ST_IDLE   = 3'd0;
  localparam state_t ST_ADDR   = 3'd1;
  localparam state_t ST_DUMMY  = 3'd2;
  localparam state_t ST_DATA   = 3'd3;
  localparam state_t ST_DONE   = 3'd4;
  localparam state_t ST_IGNORE = 3'd5;

  localparam logic [7:0] OP_READ = 8'h03;
  localparam logic [7:0] OP_FAST = 8'h0B;
  localparam logic [7:0] OP_QUAD = 8'h6B;

  localparam logic [1:0] CMD_NONE = 2'b00;
  localparam logic [1:0] CMD_READ = 2'b01;
  localparam logic [1:0] CMD_FAST = 2'b10;
  localparam logic [1:0] CMD_QUAD = 2'b11;

  // Map a completed opcode to its cmd_id; CMD_NONE means "not ours, ignore the rest".
  function automatic logic [1:0] op_to_cmd(input logic [7:0] op, input logic quad_en);
    case (op)
      OP_READ: return CMD_READ;
      OP_FAST: return CMD_FAST;
      OP_QUAD: return quad_en ? CMD_QUAD : CMD_NONE;
      default: return CMD_NONE;
    endcase
  endfunction

endpackage

// File: rtl/qspi_tx_shifter.sv
// Negedge output shifter: loads a RAM word at a byte offset, emits 1 or 4 bits per clock MSB-first.
// Latency: bits appear on dout at the negedge that shifts them; load and first shift may coincide.
// Backpressure: none; the caller must present the next word before word_empty is shifted on.
module qspi_tx_shifter #(
  parameter int RAM_DW = 16,
  parameter int OFF_W  = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              load,
  input  logic [OFF_W-1:0]  offset,
  input  logic              shift,
  input  logic              quad,
  input  logic [RAM_DW-1:0] din,
  output logic [3:0]        dout,
  output logic              last_byte_start,
  output logic              word_empty
);

  localparam int LW = $clog2(RAM_DW) + 1;
  localparam logic [LW-1:0] FULL = LW'(RAM_DW);
  localparam logic [LW-1:0] BYTE = LW'(8);

  logic [RAM_DW-1:0] word_q;
  logic [RAM_DW-1:0] src_word;
  logic [LW-1:0]     left_q;
  logic [LW-1:0]     src_left;
  logic [LW-1:0]     skip;
  logic [LW-1:0]     step;

  // Pick the bits to emit: a freshly loaded word (pre-aligned to its start byte) or the held remainder.
  always_comb begin
    skip = LW'({offset, 3'b000});
    step = quad ? LW'(4) : LW'(1);
    if (load) begin
      src_word = din << skip;
      src_left = FULL - skip;
    end else begin
      src_word = word_q;
      src_left = left_q;
    end
  end

  assign word_empty = (left_q == '0);

  // Emit the top bits, keep the remainder, and flag when the final byte of the word begins.
  always_ff @(negedge clk or negedge rst_n) begin
    if (!rst_n) begin
      word_q          <= '0;
      left_q          <= '0;
      dout            <= '0;
      last_byte_start <= 1'b0;
    end else if (shift) begin
      dout            <= quad ? src_word[RAM_DW-1 -: 4] : {2'b00, src_word[RAM_DW-1], 1'b0};
      word_q          <= src_word << step;
      left_q          <= src_left - step;
      last_byte_start <= (src_left == BYTE);
    end else begin
      dout            <= '0;
      last_byte_start <= 1'b0;
      if (load) begin
        word_q <= src_word;
        left_q <= src_left;
      end
    end
  end

endmodule

// File: rtl/qspi_rd_engine.sv
// QSPI-slave read engine (03h/0Bh, 6Bh when QSPI_QUAD_OUT_EN is defined) streaming line-RAM bytes.
// Latency: first data bit on the negedge after the last address (03h) or last dummy (0Bh/6Bh) posedge.
// Backpressure: none toward the master; qspi_rd_busy at address end turns the whole burst into FFh.
module qspi_rd_engine
  import qspi_rd_pkg::*;
#(
  parameter int ADDR_W    = 24,
  parameter int RAM_DW    = 16,
  parameter int RAM_AW    = 3,
  parameter int DUMMY_CYC = 8,
  parameter int BURST_MAX = 4
) (
  input  logic              qspi_clk,
  input  logic              rst_n,
  input  logic              qspi_csn,
  input  logic              qspi_di,
  output logic [3:0]        qspi_do,
  output logic [3:0]        qspi_oe,
  output logic [1:0]        cmd_id,
  output logic [ADDR_W-1:0] qspi_rd_addr,
  output logic              qspi_rd_req,
  input  logic              qspi_rd_busy,
  output logic              ram_ren,
  output logic [RAM_AW-1:0] ram_raddr,
  input  logic [RAM_DW-1:0] ram_rdata
);

  localparam int B     = $clog2(RAM_DW / 8);
  localparam int P     = B + RAM_AW;
  localparam int TAG_W = ADDR_W - P;
  localparam int CNT_W = 16;

`ifdef QSPI_QUAD_OUT_EN
  localparam logic QUAD_EN = 1'b1;
`else
  localparam logic QUAD_EN = 1'b0;
`endif

  localparam logic             UNLIM      = (BURST_MAX == 0);
  localparam logic             NO_DUMMY   = (DUMMY_CYC == 0);
  localparam logic [CNT_W-1:0] OP_LAST    = CNT_W'(7);
  localparam logic [CNT_W-1:0] ADDR_LAST  = CNT_W'(ADDR_W - 1);
  localparam logic [CNT_W-1:0] WIDX_LAST  = CNT_W'(ADDR_W - 1 - B);
  localparam logic [CNT_W-1:0] DUMMY_LAST = CNT_W'((DUMMY_CYC > 0) ? DUMMY_CYC - 1 : 0);
  localparam logic [CNT_W-1:0] SD_LAST    = CNT_W'((BURST_MAX > 0) ? BURST_MAX * 8 - 1 : 0);
  localparam logic [CNT_W-1:0] QD_LAST    = CNT_W'((BURST_MAX > 0) ? BURST_MAX * 2 - 1 : 0);

  state_t             state;
  logic [CNT_W-1:0]   cnt;
  logic [6:0]         op_sr;
  logic [ADDR_W-2:0]  addr_sr;
  logic [TAG_W-1:0]   last_tag;
  logic [B-1:0]       off_q;
  logic               busy_q;
  logic               first_load_q;
  logic [3:0]         oe_q;

  logic [7:0]         opcode;
  logic [1:0]         op_cmd;
  logic [ADDR_W-1:0]  addr_nxt;
  logic [TAG_W-1:0]   tag_nxt;
  logic               quad;
  logic [CNT_W-1:0]   data_last;

  logic               sh_load;
  logic [B-1:0]       sh_off;
  logic               sh_shift;
  logic [3:0]         sh_dout;
  logic               sh_lbs;
  logic               sh_empty;
  logic [RAM_DW-1:0]  sh_din;

  assign opcode    = {op_sr, qspi_di};
  assign op_cmd    = op_to_cmd(opcode, QUAD_EN);
  assign addr_nxt  = {addr_sr, qspi_di};
  assign tag_nxt   = addr_nxt[ADDR_W-1:P];
`ifdef QSPI_QUAD_OUT_EN
  assign quad      = (cmd_id == CMD_QUAD);
`else
  assign quad      = 1'b0;
`endif
  assign data_last = quad ? QD_LAST : SD_LAST;

  // Command FSM on the sampling edge: opcode, address, dummy, data count, fetch and page request.
  always_ff @(posedge qspi_clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= ST_IDLE;
      cnt          <= '0;
      op_sr        <= '0;
      addr_sr      <= '0;
      last_tag     <= '1;
      off_q        <= '0;
      busy_q       <= 1'b0;
      first_load_q <= 1'b0;
      cmd_id       <= CMD_NONE;
      qspi_rd_addr <= '0;
      qspi_rd_req  <= 1'b0;
      ram_ren      <= 1'b0;
      ram_raddr    <= '0;
    end else begin
      qspi_rd_req  <= 1'b0;
      ram_ren      <= 1'b0;
      first_load_q <= 1'b0;
      if (qspi_csn) begin
        state  <= ST_IDLE;
        cnt    <= '0;
        cmd_id <= CMD_NONE;
        busy_q <= 1'b0;
      end else begin
        case (state)
          ST_IDLE: begin
            op_sr <= opcode[6:0];
            if (cnt == OP_LAST) begin
              cnt    <= '0;
              cmd_id <= op_cmd;
              state  <= (op_cmd != CMD_NONE) ? ST_ADDR : ST_IGNORE;
            end else begin
              cnt <= cnt + CNT_W'(1);
            end
          end
          ST_ADDR: begin
            addr_sr <= addr_nxt[ADDR_W-2:0];
            // Word index is known B bits early, giving the RAM its read cycle before data starts.
            if (cnt == WIDX_LAST) begin
              ram_ren   <= 1'b1;
              ram_raddr <= addr_nxt[RAM_AW-1:0];
            end
            if (cnt == ADDR_LAST) begin
              cnt          <= '0;
              qspi_rd_addr <= {tag_nxt, {P{1'b0}}};
              off_q        <= addr_nxt[B-1:0];
              busy_q       <= qspi_rd_busy;
              first_load_q <= 1'b1;
              if (tag_nxt != last_tag) begin
                qspi_rd_req <= 1'b1;
                last_tag    <= tag_nxt;
              end
              state <= (cmd_id == CMD_READ || NO_DUMMY) ? ST_DATA : ST_DUMMY;
            end else begin
              cnt <= cnt + CNT_W'(1);
            end
          end
          ST_DUMMY: begin
            if (cnt == DUMMY_LAST) begin
              cnt   <= '0;
              state <= ST_DATA;
            end else begin
              cnt <= cnt + CNT_W'(1);
            end
          end
          ST_DATA: begin
            // Prefetch the next word (wrapping in RAM, tag fixed) as the last byte of this one starts.
            if (sh_lbs && !busy_q) begin
              ram_ren   <= 1'b1;
              ram_raddr <= ram_raddr + RAM_AW'(1);
            end
            if (!UNLIM) begin
              if (cnt == data_last) begin
                cnt   <= '0;
                state <= ST_DONE;
              end else begin
                cnt <= cnt + CNT_W'(1);
              end
            end
          end
          default: ;  // DONE and IGNORE wait for csn to rise
        endcase
      end
    end
  end

  // Lane enables follow the state one half-cycle later, on the driving edge.
  always_ff @(negedge qspi_clk or negedge rst_n) begin
    if (!rst_n) begin
      oe_q <= 4'h0;
    end else begin
      oe_q <= (state == ST_DATA) ? (quad ? 4'hF : 4'h2) : 4'h0;
    end
  end

  assign sh_shift = (state == ST_DATA);
  assign sh_load  = first_load_q | (sh_empty & sh_shift);
  assign sh_off   = first_load_q ? off_q : '0;
  assign sh_din   = busy_q ? '1 : ram_rdata;

  qspi_tx_shifter #(
    .RAM_DW (RAM_DW),
    .OFF_W  (B)
  ) u_shifter (
    .clk             (qspi_clk),
    .rst_n           (rst_n),
    .load            (sh_load),
    .offset          (sh_off),
    .shift           (sh_shift),
    .quad            (quad),
    .din             (sh_din),
    .dout            (sh_dout),
    .last_byte_start (sh_lbs),
    .word_empty      (sh_empty)
  );

`ifdef QSPI_QUAD_OUT_EN
  assign qspi_do = sh_dout;
  assign qspi_oe = oe_q;
`else
  logic unused_lanes;
  assign unused_lanes = ^{sh_dout[3:2], sh_dout[0], oe_q[3:2], oe_q[0]};
  assign qspi_do = {2'b00, sh_dout[1], 1'b0};
  assign qspi_oe = {2'b00, oe_q[1], 1'b0};
`endif

endmodule

// File: tb/tb_qspi_rd_engine.sv
// Directed bench for qspi_rd_engine: bit-banged master, line-RAM model, hand-computed expectations.
// Latency: drives di/csn just after each negedge, samples data/oe there and registered outputs after posedge.
// Backpressure: qspi_rd_busy driven directly per test.
module tb_qspi_rd_engine;

  logic        qspi_clk = 1'b0;
  logic        rst_n;
  logic        qspi_csn;
  logic        qspi_di;
  logic [3:0]  qspi_do;
  logic [3:0]  qspi_oe;
  logic [1:0]  cmd_id;
  logic [23:0] qspi_rd_addr;
  logic        qspi_rd_req;
  logic        qspi_rd_busy;
  logic        ram_ren;
  logic [2:0]  ram_raddr;
  logic [15:0] ram_rdata;

  logic [15:0] mem [8];

  int total = 0;
  int bad   = 0;

  // sampled values and per-command statistics
  logic [3:0]  s_do, s_oe;
  logic [1:0]  s_cmd;
  logic [31:0] data_w;
  logic [23:0] req_addr;
  logic [1:0]  cmd_data;
  logic [3:0]  first_oe;
  int          req_cnt, ren_cnt, oe_dummy_bad, oe_data_bad;

  always #5 qspi_clk = ~qspi_clk;

  always @(posedge qspi_clk) if (ram_ren) ram_rdata <= mem[ram_raddr];

  qspi_rd_engine dut (
    .qspi_clk     (qspi_clk),
    .rst_n        (rst_n),
    .qspi_csn     (qspi_csn),
    .qspi_di      (qspi_di),
    .qspi_do      (qspi_do),
    .qspi_oe      (qspi_oe),
    .cmd_id       (cmd_id),
    .qspi_rd_addr (qspi_rd_addr),
    .qspi_rd_req  (qspi_rd_req),
    .qspi_rd_busy (qspi_rd_busy),
    .ram_ren      (ram_ren),
    .ram_raddr    (ram_raddr),
    .ram_rdata    (ram_rdata)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input logic c, input logic d);
    @(negedge qspi_clk);
    #1;
    s_do     = qspi_do;
    s_oe     = qspi_oe;
    qspi_csn = c;
    qspi_di  = d;
    @(posedge qspi_clk);
    #1;
    s_cmd = cmd_id;
    if (qspi_rd_req === 1'b1) begin
      req_cnt++;
      req_addr = qspi_rd_addr;
    end
    if (ram_ren === 1'b1) ren_cnt++;
  endtask

  task automatic run_cmd(input logic [7:0] op, input logic [23:0] addr, input int ndummy,
                         input int ndata, input logic quad, input logic [3:0] mask);
    req_cnt = 0; ren_cnt = 0; oe_dummy_bad = 0; oe_data_bad = 0;
    data_w = '0; req_addr = '0; cmd_data = 2'bxx;
    for (int i = 7; i >= 0; i--) begin
      tick(1'b0, op[i]);
      if (i == 7) first_oe = s_oe;
    end
    for (int i = 23; i >= 0; i--) tick(1'b0, addr[i]);
    ren_cnt = 0;
    for (int i = 0; i < ndummy; i++) begin
      tick(1'b0, 1'b0);
      if (s_oe !== 4'h0) oe_dummy_bad++;
    end
    for (int i = 0; i < ndata; i++) begin
      tick(1'b0, 1'b0);
      if (i == 0) cmd_data = s_cmd;
      if (s_oe !== mask) oe_data_bad++;
      data_w = quad ? {data_w[27:0], s_do} : {data_w[30:0], s_do[1]};
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    mem[0] = 16'hA55A; mem[1] = 16'h1234; mem[2] = 16'hC3D2; mem[3] = 16'h0F1E;
    mem[4] = 16'h0000; mem[5] = 16'h0000; mem[6] = 16'h0000; mem[7] = 16'hBEEF;
    ram_rdata = '0;
    rst_n = 1'b0; qspi_csn = 1'b1; qspi_di = 1'b0; qspi_rd_busy = 1'b0;
    #2;
    chk("rst_do",    {28'd0, qspi_do},      32'h0);
    chk("rst_oe",    {28'd0, qspi_oe},      32'h0);
    chk("rst_cmd",   {30'd0, cmd_id},       32'h0);
    chk("rst_raddr", {8'd0, qspi_rd_addr},  32'h0);
    chk("rst_req",   {31'd0, qspi_rd_req},  32'h0);
    chk("rst_ren",   {31'd0, ram_ren},      32'h0);
    chk("rst_ridx",  {29'd0, ram_raddr},    32'h0);
    @(negedge qspi_clk); #1; rst_n = 1'b1;
    tick(1'b1, 1'b0); tick(1'b1, 1'b0);

    // 1: 03h at 000010h, two words, one page request
    run_cmd(8'h03, 24'h000010, 0, 32, 1'b0, 4'h2);
    chk("t1_data",    data_w,            32'hA55A1234);
    chk("t1_req_cnt", req_cnt,           32'd1);
    chk("t1_req_addr",{8'd0, req_addr},  32'h000010);
    chk("t1_cmd",     {30'd0, cmd_data}, 32'h1);
    chk("t1_oe",      oe_data_bad,       32'd0);
    chk("t1_prefetch",ren_cnt,           32'd2);
    tick(1'b1, 1'b0);
    chk("t1_cmd_idle",{30'd0, s_cmd},    32'h0);
    tick(1'b1, 1'b0);
    chk("t1_oe_idle", {28'd0, s_oe},     32'h0);

    // 2: same page, starts at word 1
    run_cmd(8'h03, 24'h000012, 0, 32, 1'b0, 4'h2);
    chk("t2_data",    data_w,  32'h1234C3D2);
    chk("t2_req_cnt", req_cnt, 32'd0);
    tick(1'b1, 1'b0); tick(1'b1, 1'b0);

    // 3: 0Bh at 00001Fh, odd byte start and RAM wrap
    run_cmd(8'h0B, 24'h00001F, 8, 32, 1'b0, 4'h2);
    chk("t3_dummy_oe", oe_dummy_bad,      32'd0);
    chk("t3_data",     data_w,            32'hEFA55A12);
    chk("t3_cmd",      {30'd0, cmd_data}, 32'h2);
    chk("t3_oe",       oe_data_bad,       32'd0);
    chk("t3_req_cnt",  req_cnt,           32'd0);
    tick(1'b1, 1'b0); tick(1'b1, 1'b0);

    // 4: refill busy at address end
    qspi_rd_busy = 1'b1;
    run_cmd(8'h03, 24'h000040, 0, 32, 1'b0, 4'h2);
    qspi_rd_busy = 1'b0;
    chk("t4_data",     data_w,           32'hFFFFFFFF);
    chk("t4_ren",      ren_cnt,          32'd0);
    chk("t4_req_cnt",  req_cnt,          32'd1);
    chk("t4_req_addr", {8'd0, req_addr}, 32'h000040);
    tick(1'b1, 1'b0); tick(1'b1, 1'b0);

    // 5: abort after 3 bits of the second byte, then an immediate new 03h
    run_cmd(8'h03, 24'h000010, 0, 11, 1'b0, 4'h2);
    chk("t5_part",     data_w,  32'h0000052A);
    chk("t5_req_cnt",  req_cnt, 32'd1);
    tick(1'b1, 1'b0);
    chk("t5_cmd_idle", {30'd0, s_cmd}, 32'h0);
    run_cmd(8'h03, 24'h000014, 0, 32, 1'b0, 4'h2);
    chk("t5_oe_off",   {28'd0, first_oe}, 32'h0);
    chk("t5_data",     data_w,            32'hC3D20F1E);
    chk("t5_req2",     req_cnt,           32'd0);
    tick(1'b1, 1'b0); tick(1'b1, 1'b0);

    // unknown opcode is ignored until csn rises
    run_cmd(8'h9F, 24'h000100, 0, 8, 1'b0, 4'h0);
    chk("unk_cmd", {30'd0, cmd_data}, 32'h0);
    chk("unk_oe",  oe_data_bad,       32'd0);
    chk("unk_req", req_cnt,           32'd0);
    tick(1'b1, 1'b0); tick(1'b1, 1'b0);

    // 6: quad output read
`ifdef QSPI_QUAD_OUT_EN
    run_cmd(8'h6B, 24'h000010, 8, 8, 1'b1, 4'hF);
    chk("t6_dummy_oe", oe_dummy_bad,      32'd0);
    chk("t6_data",     data_w,            32'hA55A1234);
    chk("t6_cmd",      {30'd0, cmd_data}, 32'h3);
    chk("t6_oe",       oe_data_bad,       32'd0);
`else
    run_cmd(8'h6B, 24'h000010, 8, 8, 1'b1, 4'h0);
    chk("t6_dummy_oe", oe_dummy_bad,      32'd0);
    chk("t6_cmd",      {30'd0, cmd_data}, 32'h0);
    chk("t6_oe",       oe_data_bad,       32'd0);
`endif
    tick(1'b1, 1'b0); tick(1'b1, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
